// File: rtl/comm_defs_pkg.sv
// comm_defs_pkg: shared ASCII constants, helpers and types for the UART command controller
package comm_defs_pkg;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_X = 8'h78;
  function automatic logic [7:0] num_to_ascii(input logic [3:0] n);
    return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
  typedef enum logic [1:0] {RDATA, DECERR, AHBERR, HADDR} rsp_kind_e;
  typedef enum logic [3:0] {S_IDLE, S_ECHO, S_STR, S_EQ, S_ZERO, S_X, S_HEX, S_CR, S_LF} tx_sched_state_e;
  localparam int MSG_MAX = 12;
  localparam int HRDATA_LEN = 6;
  localparam int HADDR_LEN = 5;
  localparam int DECERR_LEN = 12;
  localparam int AHBERR_LEN = 9;
  localparam logic [8*MSG_MAX-1:0] HRDATA_STR = "HRDATA";
  localparam logic [8*MSG_MAX-1:0] HADDR_STR = "HADDR";
  localparam logic [8*MSG_MAX-1:0] DECERR_STR = "DECODE_ERROR";
  localparam logic [8*MSG_MAX-1:0] AHBERR_STR = "AHB_ERROR";
  function automatic logic [3:0] msg_len(input rsp_kind_e k);
    return k == RDATA ? 4'(HRDATA_LEN) : k == HADDR ? 4'(HADDR_LEN) : k == DECERR ? 4'(DECERR_LEN) : 4'(AHBERR_LEN);
  endfunction
  function automatic logic has_hex(input rsp_kind_e k);
    return k == RDATA || k == HADDR;
  endfunction
  // strings are right-aligned in MSG_MAX bytes; shift the wanted character to the top byte
  function automatic logic [7:0] msg_char(input rsp_kind_e k, input logic [3:0] i);
    logic [8*MSG_MAX-1:0] s;
    s = k == RDATA ? HRDATA_STR : k == HADDR ? HADDR_STR : k == DECERR ? DECERR_STR : AHBERR_STR;
    s = s << (8 * (MSG_MAX - int'(msg_len(k)) + int'(i)));
    return s[8*MSG_MAX-1 -: 8];
  endfunction
endpackage

// File: rtl/comm_hex_ser.sv
// comm_hex_ser: holds a captured word and walks its nibbles MSB first as ASCII hex digits
module comm_hex_ser
  import comm_defs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              load,
  input  logic              adv,
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        digit,
  output logic              last
);
  localparam int NW = DATA_W / 4;
  localparam int IW = NW > 1 ? $clog2(NW) : 1;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IW-1:0] nib_q, nib_d;
  // digit follows the post-update index so the caller can register it without a bubble
  always_comb begin
    word_d = load ? data : word_q;
    nib_d = load ? IW'(NW - 1) : adv ? nib_q - 1'b1 : nib_q;
    digit = num_to_ascii(4'(word_d >> {nib_d, 2'b00}));
    last = nib_q == '0;
  end
  // captured word and nibble index
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      word_q <= '0;
      nib_q <= '0;
    end else begin
      word_q <= word_d;
      nib_q <= nib_d;
    end
endmodule

// File: rtl/comm_tx_sched.sv
// comm_tx_sched: shares the UART TX between echo bytes and formatted completion messages (echo path under COMM_TX_ECHO_EN)
module comm_tx_sched
  import comm_defs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              echo_valid,
  input  logic [7:0]        echo_data,
  output logic              echo_ready,
  input  logic              rsp_valid,
  input  logic [1:0]        rsp_kind,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy
);
  tx_sched_state_e state_q, state_d;
  rsp_kind_e kind_q;
  logic [3:0] idx_q, idx_d;
  logic [7:0] data_d, digit;
  logic valid_d, echo_win, hs, adv, last;
`ifdef COMM_TX_ECHO_EN
  logic last_rsp;
  assign echo_win = echo_valid && (!rsp_valid || last_rsp);
  // round-robin pointer: which source won the most recent grant
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) last_rsp <= 1'b1;
    else if (echo_ready || rsp_ready) last_rsp <= rsp_ready;
`else
  logic unused_echo;
  assign unused_echo = echo_valid;
  assign echo_win = 1'b0;
`endif
  assign echo_ready = state_q == S_IDLE && echo_win;
  assign rsp_ready = state_q == S_IDLE && rsp_valid && !echo_win;
  assign busy = state_q != S_IDLE || echo_ready || rsp_ready;
  assign hs = tx_valid && tx_ready;
  assign adv = hs && state_q == S_HEX && !last;
  comm_hex_ser #(.DATA_W(DATA_W)) u_hex (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .load(rsp_ready),
    .adv(adv),
    .data(rsp_data),
    .digit(digit),
    .last(last)
  );
  // next state and the byte to present after each grant or handshake
  always_comb begin
    state_d = state_q;
    valid_d = tx_valid;
    data_d = tx_data;
    idx_d = idx_q;
    case (state_q)
      S_IDLE:
        if (echo_ready) begin
          state_d = S_ECHO;
          valid_d = 1'b1;
          data_d = echo_data;
        end else if (rsp_ready) begin
          state_d = S_STR;
          valid_d = 1'b1;
          idx_d = '0;
          data_d = msg_char(rsp_kind_e'(rsp_kind), 4'd0);
        end
      S_ECHO:
        if (hs) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      S_STR:
        if (hs) begin
          if (idx_q == msg_len(kind_q) - 4'd1) begin
            state_d = has_hex(kind_q) ? S_EQ : S_CR;
            data_d = has_hex(kind_q) ? ASCII_EQ : ASCII_CR;
          end else begin
            idx_d = idx_q + 4'd1;
            data_d = msg_char(kind_q, idx_q + 4'd1);
          end
        end
      S_EQ:
        if (hs) begin
          state_d = S_ZERO;
          data_d = ASCII_0;
        end
      S_ZERO:
        if (hs) begin
          state_d = S_X;
          data_d = ASCII_X;
        end
      S_X:
        if (hs) begin
          state_d = S_HEX;
          data_d = digit;
        end
      S_HEX:
        if (hs) begin
          state_d = last ? S_CR : S_HEX;
          data_d = last ? ASCII_CR : digit;
        end
      S_CR:
        if (hs) begin
          state_d = S_LF;
          data_d = ASCII_LF;
        end
      S_LF:
        if (hs) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      default: state_d = S_IDLE;
    endcase
  end
  // state, captured report kind, string index and the registered TX byte
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q <= S_IDLE;
      kind_q <= RDATA;
      idx_q <= '0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tx_valid <= valid_d;
      tx_data <= data_d;
      if (rsp_ready) kind_q <= rsp_kind_e'(rsp_kind);
    end
endmodule

// File: tb/tb_comm_tx_sched.sv
// tb_comm_tx_sched: randomized bench with a byte-stream reference model for comm_tx_sched
module tb_comm_tx_sched;
  localparam int DATA_W = 32;
`ifdef COMM_TX_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif
  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  logic echo_valid = 1'b0;
  logic [7:0] echo_data = 8'h00;
  logic echo_ready;
  logic rsp_valid = 1'b0;
  logic [1:0] rsp_kind = 2'd0;
  logic [DATA_W-1:0] rsp_data = '0;
  logic rsp_ready;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready = 1'b0;
  logic busy;

  comm_tx_sched #(.DATA_W(DATA_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .echo_valid(echo_valid), .echo_data(echo_data), .echo_ready(echo_ready),
    .rsp_valid(rsp_valid), .rsp_kind(rsp_kind), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0, n_fail = 0, cyc = 0, bp = 100, rsp_pulses = 0, t_rdy = 0, unit_len = 0;
  bit run = 1'b0, last_rsp = 1'b1, r_acc = 1'b0, e_acc = 1'b0, ge, gr;
  logic [7:0] exp_q[$], sent_q[$], echo_q[$];
  logic [1:0] kq[$];
  logic [DATA_W-1:0] dq[$];
  string hx = "0123456789ABCDEF";
  string crlf = "\015\012";

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chk_log(input string nm, input string e);
    int bad;
    bad = -1;
    for (int i = 0; i < e.len() && bad < 0; i++)
      if (i >= sent_q.size() || sent_q[i] !== 8'(e[i])) bad = i;
    if (bad < 0 && sent_q.size() != e.len()) bad = e.len();
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: stream differs at byte %0d, actual %0d bytes, required %0d bytes", nm, bad, sent_q.size(), e.len());
    end
  endtask

  // expected byte sequence of one report, built from the message rules
  function automatic void fmt(input logic [1:0] k, input logic [DATA_W-1:0] d);
    string p;
    case (k)
      2'd0: p = "HRDATA=0x";
      2'd1: p = "DECODE_ERROR";
      2'd2: p = "AHB_ERROR";
      default: p = "HADDR=0x";
    endcase
    for (int i = 0; i < p.len(); i++) exp_q.push_back(8'(p[i]));
    if (k == 2'd0 || k == 2'd3)
      for (int i = DATA_W / 4 - 1; i >= 0; i--) exp_q.push_back(8'(hx[int'(d[4*i+:4])]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // compare process: model predicts grants when its byte queue is empty, else the byte on the wire
  always @(negedge HCLK) begin
    if (run && HRESETn) begin
      cyc++;
      if (rsp_ready) begin
        rsp_pulses++;
        t_rdy = cyc;
      end
      if (tx_valid && tx_ready) begin
        sent_q.push_back(tx_data);
        if (tx_data == 8'h0A) unit_len = cyc - t_rdy + 1;
      end
      if (exp_q.size() > 0) begin
        chk("tx_valid", tx_valid, 1);
        chk("tx_data", tx_data, exp_q[0]);
        chk("echo_ready_inflight", echo_ready, 0);
        chk("rsp_ready_inflight", rsp_ready, 0);
        chk("busy_inflight", busy, 1);
        if (tx_ready) void'(exp_q.pop_front());
      end else begin
        ge = ECHO_EN && echo_valid && (!rsp_valid || last_rsp);
        gr = rsp_valid && !ge;
        chk("tx_valid_idle", tx_valid, 0);
        chk("echo_ready", echo_ready, ge);
        chk("rsp_ready", rsp_ready, gr);
        chk("busy_idle", busy, ge || gr);
        if (ge) begin
          exp_q.push_back(echo_data);
          last_rsp = 1'b0;
          e_acc = 1'b1;
        end
        if (gr) begin
          fmt(rsp_kind, rsp_data);
          last_rsp = 1'b1;
          r_acc = 1'b1;
        end
      end
    end
  end

  // source driver: presents the head of each source queue, garbage when idle
  initial forever begin
    @(posedge HCLK);
    #1;
    if (r_acc) begin
      void'(kq.pop_front());
      void'(dq.pop_front());
      r_acc = 1'b0;
    end
    if (e_acc) begin
      void'(echo_q.pop_front());
      e_acc = 1'b0;
    end
    rsp_valid = kq.size() > 0;
    if (rsp_valid) begin
      rsp_kind = kq[0];
      rsp_data = dq[0];
    end else begin
      rsp_kind = 2'($urandom);
      rsp_data = DATA_W'($urandom);
    end
    echo_valid = echo_q.size() > 0;
    echo_data = echo_valid ? echo_q[0] : 8'($urandom);
    tx_ready = $urandom_range(99) < bp;
  end

  task automatic do_reset();
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_echo_ready", echo_ready, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    last_rsp = 1'b1;
    r_acc = 1'b0;
    e_acc = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    run = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (n < 20000 && (kq.size() > 0 || (ECHO_EN && echo_q.size() > 0) || exp_q.size() > 0)) begin
      @(negedge HCLK);
      #2;
      n++;
    end
    n_chk++;
    if (n >= 20000) begin
      n_fail++;
      $display("FAIL %s_timeout: actual=%0d cycles required<20000", nm, n);
    end
    repeat (2) @(negedge HCLK);
    #2;
  endtask

  task automatic push_rsp(input logic [1:0] k, input logic [DATA_W-1:0] d);
    kq.push_back(k);
    dq.push_back(d);
  endtask

  initial begin
    int n;
    do_reset();
    // 1: single RDATA message at full rate
    @(negedge HCLK);
    #2;
    sent_q.delete();
    rsp_pulses = 0;
    bp = 100;
    push_rsp(2'd0, 32'h0000BEEF);
    drain("t1");
    chk_log("t1_stream", {"HRDATA=0x0000BEEF", crlf});
    chk("t1_len_cycles", unit_len, 20);
    chk("t1_rsp_pulses", rsp_pulses, 1);
    // 2: DECERR under backpressure
    sent_q.delete();
    bp = 50;
    push_rsp(2'd1, DATA_W'($urandom));
    drain("t2");
    chk_log("t2_stream", {"DECODE_ERROR", crlf});
    // 3: echo and AHBERR raised together after reset
    bp = 100;
    do_reset();
    sent_q.delete();
    echo_q.push_back(8'h41);
    push_rsp(2'd2, DATA_W'($urandom));
    drain("t3");
    chk_log("t3_stream", ECHO_EN ? {"A", "AHB_ERROR", crlf} : {"AHB_ERROR", crlf});
    echo_q.delete();
    // 4: echo bytes arriving while an HADDR message is in flight
    do_reset();
    sent_q.delete();
    push_rsp(2'd3, 32'h10);
    repeat (3) @(negedge HCLK);
    #2;
    echo_q.push_back(8'h31);
    echo_q.push_back(8'h32);
    drain("t4");
    chk_log("t4_stream", ECHO_EN ? {"HADDR=0x00000010", crlf, "12"} : {"HADDR=0x00000010", crlf});
    echo_q.delete();
    // 5: reset after the 5th byte of an RDATA message
    do_reset();
    sent_q.delete();
    push_rsp(2'd0, 32'h12345678);
    n = 0;
    while (sent_q.size() < 5 && n < 200) begin
      @(negedge HCLK);
      #2;
      n++;
    end
    chk("t5_reach_5th_byte", sent_q.size() >= 5, 1);
    do_reset();
    chk_log("t5_partial", "HRDAT");
    sent_q.delete();
    push_rsp(2'd0, 32'hCAFE0001);
    drain("t5");
    chk_log("t5_restart", {"HRDATA=0xCAFE0001", crlf});
    // 6: random mix of echo bytes and reports with random backpressure
    for (int u = 0; u < 80; u++) begin
      bp = $urandom_range(100, 30);
      if ($urandom_range(1) == 1) echo_q.push_back(8'($urandom));
      else push_rsp(2'($urandom), DATA_W'($urandom));
      repeat ($urandom_range(6)) @(negedge HCLK);
      #2;
    end
    drain("t6");
    echo_q.delete();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
